// File: rtl/zube_fifo_mailbox_if.sv
// Bus bundle for zube_fifo_mailbox: the Z80 I/O side (through the external
// 8-bit transceiver) and the Caravel Wishbone slave side, plus the SoC IRQ.
//   slave  : modport used by the mailbox itself
//   master : modport used by whatever drives the mailbox (SoC/Z80 model)
// Ports carried:
//   z80_write_strobe_b, z80_read_strobe_b  Z80 I/O strobes, active low, async
//   z80_address_bus[7:0], z80_data_bus_in[7:0]
//   z80_data_bus_out[7:0], z80_bus_dir     transceiver data / direction
//   wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in[31:0], wb_data_in[31:0]
//   wb_ack_out, wb_stall_out, wb_data_out[31:0]
//   irq_out                                level SoC interrupt
interface zube_fifo_mailbox_if;
  logic        z80_write_strobe_b;
  logic        z80_read_strobe_b;
  logic [7:0]  z80_address_bus;
  logic [7:0]  z80_data_bus_in;
  logic [7:0]  z80_data_bus_out;
  logic        z80_bus_dir;
  logic        wb_cyc_in;
  logic        wb_stb_in;
  logic        wb_we_in;
  logic [31:0] wb_addr_in;
  logic [31:0] wb_data_in;
  logic        wb_ack_out;
  logic        wb_stall_out;
  logic [31:0] wb_data_out;
  logic        irq_out;

  modport slave (
    input  z80_write_strobe_b, z80_read_strobe_b, z80_address_bus, z80_data_bus_in,
    input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
    output z80_data_bus_out, z80_bus_dir,
    output wb_ack_out, wb_stall_out, wb_data_out, irq_out
  );

  modport master (
    output z80_write_strobe_b, z80_read_strobe_b, z80_address_bus, z80_data_bus_in,
    output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
    input  z80_data_bus_out, z80_bus_dir,
    input  wb_ack_out, wb_stall_out, wb_data_out, irq_out
  );
endinterface

// File: rtl/zube_fifo_mailbox.sv
// Z80 <-> SoC mailbox with two byte FIFOs (TX: Z80->SoC, RX: SoC->Z80),
// Z80-visible flags, sticky error bits and maskable level IRQ.
// Ports:
//   clk      Wishbone clock, everything on posedge
//   reset_b  synchronous reset, active low
//   bus      zube_fifo_mailbox_if.slave (Z80 I/O side + Wishbone + irq_out)
// Wishbone map (from BASE_ADDRESS): +0 CFG, +4 DATA, +8 STATUS, +C IRQ.
// Z80 map (from CFG base B): B+0 TX push / RX pop, B+1 flags, B+2 status bytes.
//
// Z80-side state machine:
//   state    | meaning
//   ST_IDLE  | no Z80 access in flight, watching synced strobe falling edges
//   ST_WRITE | write strobe low, base latched, commit on strobe rising edge
//   ST_READ  | read strobe low, transceiver driving, release/pop on rising edge
module zube_fifo_mailbox #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          DEPTH_LOG2   = 3,
  parameter logic [7:0]  Z80_BASE_RST = 8'h80
) (
  input  logic                 clk,
  input  logic                 reset_b,
  zube_fifo_mailbox_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int AW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] IDX_MASK = PW'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} z80_state_e;

  function automatic logic [AW-1:0] idx(input logic [PW-1:0] p);
    return AW'(p & IDX_MASK);
  endfunction

  // synchronisers and edge history
  logic [1:0] wr_s_q, wr_s_d, rd_s_q, rd_s_d;
  logic       wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [7:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
  logic [7:0] din_s1_q, din_s1_d, din_s2_q, din_s2_d;

  // Z80 FSM
  z80_state_e state_q, state_d;
  logic [7:0] base_lat_q, base_lat_d;
  logic       rd_pop_q, rd_pop_d;
  logic       dir_q, dir_d;
  logic [7:0] dout_q, dout_d;

  // registers
  logic [7:0]  z80_base_q, z80_base_d;
  logic [2:0]  en_q, en_d;
  logic [7:0]  status_in_q, status_in_d;
  logic [7:0]  status_out_q, status_out_d;
  logic        pend_status_q, pend_status_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_unf_q, rx_unf_d;
  logic        ack_q, ack_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        irq_q, irq_d;

  // FIFOs
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0] tx_count, rx_count;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]    tx_head, rx_head;
  logic          tx_push, tx_pop, rx_push, rx_pop, tx_push_ok, rx_push_ok;
  logic [7:0]    tx_push_data, rx_push_data;

  logic        wr_rise, wr_fall, rd_rise, rd_fall;
  logic [31:0] wb_off;
  logic        wb_hit;
  logic [1:0]  reg_sel;
  logic [7:0]  rd_off, wr_off;
  logic        err_any;
  logic [7:0]  flags;
  logic        unused_bits;

  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_count = rx_wr_q - rx_rd_q;
  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == DEPTH_P);
  assign rx_full  = (rx_count == DEPTH_P);
  assign tx_head  = tx_mem_q[idx(tx_rd_q)];
  assign rx_head  = rx_mem_q[idx(rx_rd_q)];

  // strobes are active low: "rise" is end of Z80 cycle, "fall" is start
  assign wr_rise = wr_s_q[1] & ~wr_prev_q;
  assign wr_fall = ~wr_s_q[1] & wr_prev_q;
  assign rd_rise = rd_s_q[1] & ~rd_prev_q;
  assign rd_fall = ~rd_s_q[1] & rd_prev_q;

  assign wb_off  = bus.wb_addr_in - BASE_ADDRESS;
  assign wb_hit  = bus.wb_cyc_in & bus.wb_stb_in & (wb_off[31:4] == '0) & (wb_off[1:0] == 2'b00);
  assign reg_sel = wb_off[3:2];

  assign rd_off  = addr_s2_q - z80_base_q;
  assign wr_off  = addr_s2_q - base_lat_q;
  assign err_any = tx_ovf_q | rx_ovf_q | rx_unf_q;
  assign flags   = {4'b0, rx_unf_q, tx_ovf_q, tx_full, ~rx_empty};

  assign unused_bits = ^{bus.wb_data_in[31:11]};

  always_comb begin
    wr_s_d    = {wr_s_q[0], bus.z80_write_strobe_b};
    rd_s_d    = {rd_s_q[0], bus.z80_read_strobe_b};
    wr_prev_d = wr_s_q[1];
    rd_prev_d = rd_s_q[1];
    addr_s1_d = bus.z80_address_bus;
    addr_s2_d = addr_s1_q;
    din_s1_d  = bus.z80_data_bus_in;
    din_s2_d  = din_s1_q;

    state_d       = state_q;
    base_lat_d    = base_lat_q;
    rd_pop_d      = rd_pop_q;
    dir_d         = dir_q;
    dout_d        = dout_q;
    z80_base_d    = z80_base_q;
    en_d          = en_q;
    status_in_d   = status_in_q;
    status_out_d  = status_out_q;
    pend_status_d = pend_status_q;
    tx_ovf_d      = tx_ovf_q;
    rx_ovf_d      = rx_ovf_q;
    rx_unf_d      = rx_unf_q;
    ack_d         = 1'b0;
    wb_dat_d      = wb_dat_q;
    tx_push       = 1'b0;
    tx_push_data  = '0;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    rx_push_data  = '0;
    rx_pop        = 1'b0;

    // Wishbone side first so that same-clock Z80/FIFO error sets win over W1C
    if (wb_hit) begin
      ack_d    = 1'b1;
      wb_dat_d = '0;
      case (reg_sel)
        2'd0: begin
          if (bus.wb_we_in) begin
            z80_base_d = bus.wb_data_in[7:0];
            en_d       = bus.wb_data_in[10:8];
          end else begin
            wb_dat_d = {21'b0, en_q, z80_base_q};
          end
        end
        2'd1: begin
          if (bus.wb_we_in) begin
            rx_push      = 1'b1;
            rx_push_data = bus.wb_data_in[7:0];
          end else if (!tx_empty) begin
            tx_pop   = 1'b1;
            wb_dat_d = {23'b0, 1'b1, tx_head};
          end
        end
        2'd2: begin
          if (bus.wb_we_in) begin
            status_in_d = bus.wb_data_in[7:0];
          end else begin
            wb_dat_d      = {8'b0, 8'(tx_count), 8'(rx_count), status_out_q};
            pend_status_d = 1'b0;
          end
        end
        default: begin
          if (bus.wb_we_in) begin
            if (bus.wb_data_in[1]) pend_status_d = 1'b0;
            if (bus.wb_data_in[2]) begin
              tx_ovf_d = 1'b0;
              rx_ovf_d = 1'b0;
              rx_unf_d = 1'b0;
            end
          end else begin
            wb_dat_d = {29'b0, err_any, pend_status_q, ~tx_empty};
          end
        end
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_fall) begin
          state_d    = ST_WRITE;
          base_lat_d = z80_base_q;
        end else if (rd_fall && (rd_off <= 8'd2)) begin
          state_d  = ST_READ;
          dir_d    = 1'b1;
          rd_pop_d = 1'b0;
          case (rd_off)
            8'd0: begin
              if (rx_empty) begin
                dout_d   = 8'hFF;
                rx_unf_d = 1'b1;
              end else begin
                dout_d   = rx_head;
                rd_pop_d = 1'b1;
              end
            end
            8'd1:    dout_d = flags;
            default: dout_d = status_in_q;
          endcase
        end
      end
      ST_WRITE: begin
        if (wr_rise) begin
          state_d = ST_IDLE;
          if (wr_off == 8'd0) begin
            tx_push      = 1'b1;
            tx_push_data = din_s2_q;
          end else if (wr_off == 8'd2) begin
            status_out_d  = din_s2_q;
            pend_status_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_rise) begin
          state_d  = ST_IDLE;
          dir_d    = 1'b0;
          rx_pop   = rd_pop_q;
          rd_pop_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a pop in the same clock frees the slot for a push into a full FIFO
    tx_push_ok = tx_push & (~tx_full | tx_pop);
    rx_push_ok = rx_push & (~rx_full | rx_pop);
    if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
    if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;

    tx_wr_d = tx_wr_q + PW'(tx_push_ok);
    tx_rd_d = tx_rd_q + PW'(tx_pop);
    rx_wr_d = rx_wr_q + PW'(rx_push_ok);
    rx_rd_d = rx_rd_q + PW'(rx_pop);

    irq_d = |({err_any, pend_status_q, ~tx_empty} & en_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      wr_s_q        <= 2'b11;
      rd_s_q        <= 2'b11;
      wr_prev_q     <= 1'b1;
      rd_prev_q     <= 1'b1;
      addr_s1_q     <= '0;
      addr_s2_q     <= '0;
      din_s1_q      <= '0;
      din_s2_q      <= '0;
      state_q       <= ST_IDLE;
      base_lat_q    <= Z80_BASE_RST;
      rd_pop_q      <= 1'b0;
      dir_q         <= 1'b0;
      dout_q        <= '0;
      z80_base_q    <= Z80_BASE_RST;
      en_q          <= '0;
      status_in_q   <= '0;
      status_out_q  <= '0;
      pend_status_q <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      rx_unf_q      <= 1'b0;
      ack_q         <= 1'b0;
      wb_dat_q      <= '0;
      irq_q         <= 1'b0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
    end else begin
      wr_s_q        <= wr_s_d;
      rd_s_q        <= rd_s_d;
      wr_prev_q     <= wr_prev_d;
      rd_prev_q     <= rd_prev_d;
      addr_s1_q     <= addr_s1_d;
      addr_s2_q     <= addr_s2_d;
      din_s1_q      <= din_s1_d;
      din_s2_q      <= din_s2_d;
      state_q       <= state_d;
      base_lat_q    <= base_lat_d;
      rd_pop_q      <= rd_pop_d;
      dir_q         <= dir_d;
      dout_q        <= dout_d;
      z80_base_q    <= z80_base_d;
      en_q          <= en_d;
      status_in_q   <= status_in_d;
      status_out_q  <= status_out_d;
      pend_status_q <= pend_status_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      rx_unf_q      <= rx_unf_d;
      ack_q         <= ack_d;
      wb_dat_q      <= wb_dat_d;
      irq_q         <= irq_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
    end
  end

  // storage needs no reset: emptiness is carried by the pointers
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[idx(tx_wr_q)] <= tx_push_data;
    if (rx_push_ok) rx_mem_q[idx(rx_wr_q)] <= rx_push_data;
  end

  assign bus.z80_data_bus_out = dout_q;
  assign bus.z80_bus_dir      = dir_q;
  assign bus.wb_ack_out       = ack_q;
  assign bus.wb_stall_out     = 1'b0;
  assign bus.wb_data_out      = wb_dat_q;
  assign bus.irq_out          = irq_q;

endmodule

// File: tb/tb_zube_fifo_mailbox.sv
module tb_zube_fifo_mailbox;
  localparam logic [31:0] WB_BASE = 32'h3000_0000;
  localparam logic [1:0] OP_WBW = 2'd0, OP_WBR = 2'd1, OP_ZW = 2'd2, OP_ZR = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_b;
  int checks = 0;
  int failures = 0;

  zube_fifo_mailbox_if bus ();

  zube_fifo_mailbox #(
    .BASE_ADDRESS(WB_BASE),
    .DEPTH_LOG2  (3),
    .Z80_BASE_RST(8'h80)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] off, input logic [31:0] wdata,
                           output logic ack, output logic [31:0] rdata);
    @(posedge clk); #1;
    bus.wb_cyc_in  = 1'b1;
    bus.wb_stb_in  = 1'b1;
    bus.wb_we_in   = we;
    bus.wb_addr_in = WB_BASE + off;
    bus.wb_data_in = wdata;
    @(posedge clk); #1;
    ack   = bus.wb_ack_out;
    rdata = bus.wb_data_out;
    bus.wb_cyc_in = 1'b0;
    bus.wb_stb_in = 1'b0;
    bus.wb_we_in  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] off, input logic [31:0] wdata);
    logic a;
    logic [31:0] d;
    wb_access(1'b1, off, wdata, a, d);
    check("wb_wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic wb_rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic a;
    logic [31:0] d;
    wb_access(1'b0, off, 32'h0, a, d);
    check({name, "_ack"}, {31'b0, a}, 32'd1);
    check(name, d, exp);
  endtask

  task automatic z80_wr(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus.z80_address_bus    = addr;
    bus.z80_data_bus_in    = data;
    bus.z80_write_strobe_b = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.z80_write_strobe_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic z80_rd(input logic [7:0] addr, output logic [7:0] data,
                        output logic dir_hi, output logic dir_after);
    @(posedge clk); #1;
    bus.z80_address_bus   = addr;
    bus.z80_read_strobe_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dir_hi = bus.z80_bus_dir;
    data   = bus.z80_data_bus_out;
    bus.z80_read_strobe_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    dir_after = bus.z80_bus_dir;
  endtask

  vec_t vecs[29];

  initial begin
    logic        a, dh, dl;
    logic [7:0]  zd;
    logic [31:0] d;

    vecs[0]  = '{OP_WBR, 32'h0, 32'h0,  32'h0000_0080};
    vecs[1]  = '{OP_WBR, 32'h8, 32'h0,  32'h0};
    vecs[2]  = '{OP_ZW,  32'h80, 32'h11, 32'h0};
    vecs[3]  = '{OP_ZW,  32'h80, 32'h22, 32'h0};
    vecs[4]  = '{OP_WBR, 32'h4, 32'h0,  32'h111};
    vecs[5]  = '{OP_WBR, 32'h4, 32'h0,  32'h122};
    vecs[6]  = '{OP_WBR, 32'h4, 32'h0,  32'h000};
    vecs[7]  = '{OP_WBW, 32'h4, 32'hA5, 32'h0};
    vecs[8]  = '{OP_ZR,  32'h80, 32'h0, 32'hA5};
    vecs[9]  = '{OP_ZR,  32'h80, 32'h0, 32'hFF};
    vecs[10] = '{OP_ZR,  32'h81, 32'h0, 32'h08};
    vecs[11] = '{OP_WBR, 32'hC, 32'h0,  32'h4};
    vecs[12] = '{OP_WBW, 32'hC, 32'h4,  32'h0};
    vecs[13] = '{OP_WBR, 32'hC, 32'h0,  32'h0};
    vecs[14] = '{OP_WBW, 32'h8, 32'h3C, 32'h0};
    vecs[15] = '{OP_ZR,  32'h82, 32'h0, 32'h3C};
    vecs[16] = '{OP_WBR, 32'h8, 32'h0,  32'h0};
    vecs[17] = '{OP_ZW,  32'h80, 32'h33, 32'h0};
    vecs[18] = '{OP_WBR, 32'h8, 32'h0,  32'h0001_0000};
    vecs[19] = '{OP_WBR, 32'hC, 32'h0,  32'h1};
    vecs[20] = '{OP_WBR, 32'h4, 32'h0,  32'h133};
    vecs[21] = '{OP_WBW, 32'h4, 32'h01, 32'h0};
    vecs[22] = '{OP_WBW, 32'h4, 32'h02, 32'h0};
    vecs[23] = '{OP_WBR, 32'h8, 32'h0,  32'h0000_0200};
    vecs[24] = '{OP_ZR,  32'h80, 32'h0, 32'h01};
    vecs[25] = '{OP_ZR,  32'h81, 32'h0, 32'h01};
    vecs[26] = '{OP_ZR,  32'h80, 32'h0, 32'h02};
    vecs[27] = '{OP_ZW,  32'h81, 32'hFF, 32'h0};
    vecs[28] = '{OP_WBR, 32'h8, 32'h0,  32'h0};

    reset_b = 1'b0;
    bus.z80_write_strobe_b = 1'b1;
    bus.z80_read_strobe_b  = 1'b1;
    bus.z80_address_bus    = 8'h00;
    bus.z80_data_bus_in    = 8'h00;
    bus.wb_cyc_in  = 1'b0;
    bus.wb_stb_in  = 1'b0;
    bus.wb_we_in   = 1'b0;
    bus.wb_addr_in = 32'h0;
    bus.wb_data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {31'b0, bus.irq_out}, 32'd0);
    check("rst_dir", {31'b0, bus.z80_bus_dir}, 32'd0);
    check("rst_dout", {24'b0, bus.z80_data_bus_out}, 32'd0);
    check("rst_ack", {31'b0, bus.wb_ack_out}, 32'd0);
    check("rst_stall", {31'b0, bus.wb_stall_out}, 32'd0);

    for (int i = 0; i < 29; i++) begin
      case (vecs[i].op)
        OP_WBW: wb_wr(vecs[i].addr, vecs[i].data);
        OP_WBR: wb_rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        OP_ZW:  z80_wr(vecs[i].addr[7:0], vecs[i].data[7:0]);
        default: begin
          z80_rd(vecs[i].addr[7:0], zd, dh, dl);
          check($sformatf("vec%0d_zdata", i), {24'b0, zd}, vecs[i].exp);
          check($sformatf("vec%0d_dir_hi", i), {31'b0, dh}, 32'd1);
          check($sformatf("vec%0d_dir_lo", i), {31'b0, dl}, 32'd0);
        end
      endcase
    end

    // TX overflow at DEPTH=8, error IRQ and W1C
    for (int i = 0; i < 9; i++) z80_wr(8'h80, 8'(8'hA0 + i));
    z80_rd(8'h81, zd, dh, dl);
    check("ovf_flags", {24'b0, zd}, 32'h06);
    wb_rd_chk("ovf_count", 32'h8, 32'h0008_0000);
    wb_wr(32'h0, 32'h0000_0480);
    repeat (3) @(posedge clk);
    #1 check("err_irq_on", {31'b0, bus.irq_out}, 32'd1);
    wb_rd_chk("err_irq_reg", 32'hC, 32'h5);
    wb_wr(32'hC, 32'h4);
    repeat (3) @(posedge clk);
    #1 check("err_irq_off", {31'b0, bus.irq_out}, 32'd0);
    for (int i = 0; i < 8; i++) wb_rd_chk($sformatf("ovf_drain%0d", i), 32'h4, 32'h1A0 + i);
    wb_rd_chk("ovf_drain_empty", 32'h4, 32'h0);

    // status IRQ
    wb_wr(32'h0, 32'h0000_0280);
    z80_wr(8'h82, 8'h5A);
    repeat (3) @(posedge clk);
    #1 check("st_irq_on", {31'b0, bus.irq_out}, 32'd1);
    wb_rd_chk("st_read", 32'h8, 32'h0000_005A);
    repeat (3) @(posedge clk);
    #1 check("st_irq_off", {31'b0, bus.irq_out}, 32'd0);

    // base move to 0x40
    wb_wr(32'h0, 32'h0000_0040);
    z80_wr(8'h80, 8'h77);
    wb_rd_chk("base_old_ignored", 32'h4, 32'h0);
    z80_wr(8'h40, 8'h66);
    wb_rd_chk("base_new_push", 32'h4, 32'h166);
    z80_rd(8'h80, zd, dh, dl);
    check("base_old_rd_dir", {31'b0, dh}, 32'd0);
    z80_rd(8'h41, zd, dh, dl);
    check("base_new_flags", {24'b0, zd}, 32'h00);

    // full TX: WB pop and Z80 push commit in the same clock
    for (int i = 0; i < 8; i++) z80_wr(8'h40, 8'(8'h10 + i));
    @(posedge clk); #1;
    bus.z80_address_bus    = 8'h40;
    bus.z80_data_bus_in    = 8'hEE;
    bus.z80_write_strobe_b = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.z80_write_strobe_b = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    bus.wb_cyc_in  = 1'b1;
    bus.wb_stb_in  = 1'b1;
    bus.wb_we_in   = 1'b0;
    bus.wb_addr_in = WB_BASE + 32'h4;
    @(posedge clk); #1;
    check("simul_ack", {31'b0, bus.wb_ack_out}, 32'd1);
    check("simul_pop", bus.wb_data_out, 32'h110);
    bus.wb_cyc_in = 1'b0;
    bus.wb_stb_in = 1'b0;
    repeat (4) @(posedge clk);
    wb_rd_chk("simul_count", 32'h8, 32'h0008_005A);
    z80_rd(8'h41, zd, dh, dl);
    check("simul_flags", {24'b0, zd}, 32'h02);
    for (int i = 1; i < 8; i++) wb_rd_chk($sformatf("simul_drain%0d", i), 32'h4, 32'h110 + i);
    wb_rd_chk("simul_drain_last", 32'h4, 32'h1EE);
    wb_rd_chk("simul_empty", 32'h4, 32'h0);

    // base change while a Z80 write is in flight
    @(posedge clk); #1;
    bus.z80_address_bus    = 8'h40;
    bus.z80_data_bus_in    = 8'hC3;
    bus.z80_write_strobe_b = 1'b0;
    repeat (4) @(posedge clk);
    wb_wr(32'h0, 32'h0000_0080);
    #1 bus.z80_write_strobe_b = 1'b1;
    repeat (4) @(posedge clk);
    wb_rd_chk("inflight_push", 32'h4, 32'h1C3);

    // unmapped Wishbone address never acked
    wb_access(1'b0, 32'h10, 32'h0, a, d);
    check("unmapped_noack", {31'b0, a}, 32'd0);

    // reset in the middle of a Z80 read with a Wishbone strobe pending
    wb_wr(32'h4, 32'h99);
    @(posedge clk); #1;
    bus.z80_address_bus   = 8'h80;
    bus.z80_read_strobe_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_dir_before", {31'b0, bus.z80_bus_dir}, 32'd1);
    check("midrst_data", {24'b0, bus.z80_data_bus_out}, 32'h99);
    reset_b        = 1'b0;
    bus.wb_cyc_in  = 1'b1;
    bus.wb_stb_in  = 1'b1;
    bus.wb_addr_in = WB_BASE;
    @(posedge clk); #1;
    check("midrst_dir", {31'b0, bus.z80_bus_dir}, 32'd0);
    bus.wb_cyc_in = 1'b0;
    bus.wb_stb_in = 1'b0;
    @(posedge clk); #1;
    check("midrst_noack", {31'b0, bus.wb_ack_out}, 32'd0);
    reset_b = 1'b1;
    bus.z80_read_strobe_b = 1'b1;
    repeat (6) @(posedge clk);
    wb_rd_chk("midrst_flushed", 32'h8, 32'h0);
    wb_rd_chk("midrst_cfg", 32'h0, 32'h80);
    check("midrst_irq", {31'b0, bus.irq_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
